// File: rtl/muldiv_wb_buf.sv
// Writeback buffer for the divider and multiplier result pulses.
// Each source feeds its own small FIFO. A round-robin arbiter with a grant
// lock drives a single valid/ready writeback port from the FIFO heads.
module muldiv_wb_buf #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_ex_i,
    input  logic                 div_vld_i,
    input  logic [ADDR_BITS-1:0] div_trans_id_i,
    input  logic [31:0]          div_result_i,
    input  logic                 mul_vld_i,
    input  logic [ADDR_BITS-1:0] mul_trans_id_i,
    input  logic [31:0]          mul_result_i,
    input  logic                 wb_rdy_i,
    output logic                 wb_vld_o,
    output logic [ADDR_BITS-1:0] wb_trans_id_o,
    output logic [31:0]          wb_result_o,
    output logic                 wb_src_o,
    output logic                 div_full_o,
    output logic                 mul_full_o,
    output logic                 ovf_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = ADDR_BITS + 32;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    // Source index 0 = mul, 1 = div (matches wb_src_o encoding)
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [EW-1:0] mem_q  [2][DEPTH];
    logic [EW-1:0] mem_d  [2][DEPTH];

    logic [0:0] state_q, state_d;
    logic       src_q, src_d;
    logic       last_q, last_d;
    logic       ovf_q, ovf_d;

    logic [1:0]    in_vld;
    logic [EW-1:0] in_ent [2];
    logic [1:0]    full;
    logic [1:0]    pop;
    logic [1:0]    push;
    logic [1:0]    nonempty_d;
    logic          hs;
    logic [EW-1:0] head;

    assign in_vld    = {div_vld_i, mul_vld_i};
    assign in_ent[0] = {mul_trans_id_i, mul_result_i};
    assign in_ent[1] = {div_trans_id_i, div_result_i};

    assign full[0] = (cnt_q[0] == FULL_CNT);
    assign full[1] = (cnt_q[1] == FULL_CNT);

    assign hs       = (state_q == S_PRESENT) && wb_rdy_i;
    assign head     = mem_q[src_q][rptr_q[src_q]];
    assign wb_vld_o = (state_q == S_PRESENT);

    assign wb_trans_id_o = wb_vld_o ? head[EW-1:32] : '0;
    assign wb_result_o   = wb_vld_o ? head[31:0]    : '0;
    assign wb_src_o      = src_q;
    assign mul_full_o    = full[0];
    assign div_full_o    = full[1];
    assign ovf_o         = ovf_q;

    // FIFO push/pop, overflow detection and flush
    always_comb begin
        mem_d  = mem_q;
        ovf_d  = ovf_q;
        pop    = '0;
        push   = '0;
        nonempty_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i]  = cnt_q[i];
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            pop[i]    = hs && (src_q == i[0]);
            // A full FIFO still accepts a pulse when its head pops on the same edge
            push[i]   = in_vld[i] && !flush_ex_i && (!full[i] || pop[i]);
            if (in_vld[i] && !flush_ex_i && full[i] && !pop[i]) begin
                ovf_d = 1'b1;
            end
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = in_ent[i];
                wptr_d[i] = wptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rptr_d[i] = rptr_q[i] + PW'(1);
            end
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
            if (flush_ex_i) begin
                cnt_d[i]  = '0;
                wptr_d[i] = '0;
                rptr_d[i] = '0;
            end
            nonempty_d[i] = (cnt_d[i] != '0);
        end
    end

    // Grant-lock FSM with round-robin selection on post-update occupancy
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        last_d  = hs ? src_q : last_q;
        if (flush_ex_i) begin
            state_d = S_IDLE;
        end else if ((state_q == S_IDLE) || hs) begin
            if (|nonempty_d) begin
                state_d = S_PRESENT;
                src_d   = (nonempty_d == 2'b11) ? ~last_d : nonempty_d[1];
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '{default: '0};
            wptr_q  <= '{default: '0};
            rptr_q  <= '{default: '0};
            mem_q   <= '{default: '0};
            state_q <= S_IDLE;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            mem_q   <= mem_d;
            state_q <= state_d;
            src_q   <= src_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_muldiv_wb_buf.sv
// Directed self-checking bench for muldiv_wb_buf (DEPTH=2, ADDR_BITS=3).
module tb_muldiv_wb_buf;

    logic        clk;
    logic        rst_n;
    logic        flush_ex;
    logic        div_vld;
    logic [2:0]  div_id;
    logic [31:0] div_res;
    logic        mul_vld;
    logic [2:0]  mul_id;
    logic [31:0] mul_res;
    logic        wb_rdy;
    logic        wb_vld;
    logic [2:0]  wb_id;
    logic [31:0] wb_res;
    logic        wb_src;
    logic        div_full;
    logic        mul_full;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    muldiv_wb_buf #(.DEPTH(2), .ADDR_BITS(3)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_ex_i     (flush_ex),
        .div_vld_i      (div_vld),
        .div_trans_id_i (div_id),
        .div_result_i   (div_res),
        .mul_vld_i      (mul_vld),
        .mul_trans_id_i (mul_id),
        .mul_result_i   (mul_res),
        .wb_rdy_i       (wb_rdy),
        .wb_vld_o       (wb_vld),
        .wb_trans_id_o  (wb_id),
        .wb_result_o    (wb_res),
        .wb_src_o       (wb_src),
        .div_full_o     (div_full),
        .mul_full_o     (mul_full),
        .ovf_o          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of pulses, advance past the edge, then drop the pulses
    task automatic drive(input logic mv, input logic [2:0] mi, input logic [31:0] mr,
                         input logic dv, input logic [2:0] di, input logic [31:0] dr);
        mul_vld = mv; mul_id = mi; mul_res = mr;
        div_vld = dv; div_id = di; div_res = dr;
        tick();
        mul_vld = 1'b0; div_vld = 1'b0;
    endtask

    task automatic beat(input string tag, input logic s, input logic [2:0] id, input logic [31:0] r);
        chk({tag, "_vld"}, 64'(wb_vld), 64'(1'b1));
        chk({tag, "_src"}, 64'(wb_src), 64'(s));
        chk({tag, "_id"},  64'(wb_id),  64'(id));
        chk({tag, "_res"}, 64'(wb_res), 64'(r));
    endtask

    initial begin
        rst_n = 1'b0; flush_ex = 1'b0; wb_rdy = 1'b0;
        div_vld = 1'b0; div_id = '0; div_res = '0;
        mul_vld = 1'b0; mul_id = '0; mul_res = '0;

        // Reset values
        #2;
        chk("rst_vld",   64'(wb_vld),   64'(1'b0));
        chk("rst_id",    64'(wb_id),    64'(3'd0));
        chk("rst_res",   64'(wb_res),   64'(32'd0));
        chk("rst_src",   64'(wb_src),   64'(1'b0));
        chk("rst_dfull", 64'(div_full), 64'(1'b0));
        chk("rst_mfull", 64'(mul_full), 64'(1'b0));
        chk("rst_ovf",   64'(ovf),      64'(1'b0));
        #20 rst_n = 1'b1;
        tick();

        // Single div pulse: one beat, one cycle after the pulse
        wb_rdy = 1'b1;
        chk("t1_pre_vld", 64'(wb_vld), 64'(1'b0));
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 32'h0000_0007);
        beat("t1", 1'b1, 3'd3, 32'h7);
        tick();
        chk("t1_post_vld", 64'(wb_vld), 64'(1'b0));
        chk("t1_post_res", 64'(wb_res), 64'(32'd0));

        // Simultaneous mul and div pulses: mul first, then div
        drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
        beat("t2a", 1'b0, 3'd1, 32'h11);
        tick();
        beat("t2b", 1'b1, 3'd2, 32'h22);
        tick();
        chk("t2_end_vld", 64'(wb_vld), 64'(1'b0));

        // Stalled port, three div pulses into a 2-deep FIFO
        wb_rdy = 1'b0;
        repeat (5) tick();
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd4, 32'h44);
        chk("t3_full1", 64'(div_full), 64'(1'b0));
        beat("t3_p1", 1'b1, 3'd4, 32'h44);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 32'h45);
        chk("t3_full2", 64'(div_full), 64'(1'b1));
        chk("t3_ovf2",  64'(ovf),      64'(1'b0));
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 32'h46);
        chk("t3_full3", 64'(div_full), 64'(1'b1));
        chk("t3_ovf3",  64'(ovf),      64'(1'b1));
        beat("t3_hold", 1'b1, 3'd4, 32'h44);
        repeat (3) tick();
        chk("t3_ovf_sticky", 64'(ovf), 64'(1'b1));
        wb_rdy = 1'b1;
        tick();
        beat("t3_second", 1'b1, 3'd5, 32'h45);
        tick();
        chk("t3_dropped_vld", 64'(wb_vld), 64'(1'b0));
        chk("t3_ovf_end",     64'(ovf),    64'(1'b1));

        // Asynchronous reset mid-operation
        wb_rdy = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 32'h91);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h92);
        rst_n = 1'b0;
        #2;
        chk("t4_arst_vld",   64'(wb_vld),   64'(1'b0));
        chk("t4_arst_dfull", 64'(div_full), 64'(1'b0));
        chk("t4_arst_ovf",   64'(ovf),      64'(1'b0));
        chk("t4_arst_id",    64'(wb_id),    64'(3'd0));
        rst_n = 1'b1;
        tick();

        // Full FIFO popped on the same edge as a new pulse
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 32'hA1);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'hA2);
        chk("t4_full", 64'(div_full), 64'(1'b1));
        wb_rdy = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 32'hA3);
        chk("t4_still_full", 64'(div_full), 64'(1'b1));
        chk("t4_no_ovf",     64'(ovf),      64'(1'b0));
        beat("t4_b2", 1'b1, 3'd2, 32'hA2);
        tick();
        beat("t4_b3", 1'b1, 3'd3, 32'hA3);
        chk("t4_not_full", 64'(div_full), 64'(1'b0));
        tick();
        chk("t4_end_vld", 64'(wb_vld), 64'(1'b0));

        // Stalled div beat while mul fills; then round robin
        wb_rdy = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 32'h55);
        beat("t5_a", 1'b1, 3'd5, 32'h55);
        drive(1'b1, 3'd1, 32'h61, 1'b0, 3'd0, 32'h0);
        beat("t5_b", 1'b1, 3'd5, 32'h55);
        drive(1'b1, 3'd2, 32'h62, 1'b1, 3'd6, 32'h56);
        beat("t5_c", 1'b1, 3'd5, 32'h55);
        chk("t5_mfull", 64'(mul_full), 64'(1'b1));
        wb_rdy = 1'b1;
        tick();
        beat("t5_rr1", 1'b0, 3'd1, 32'h61);
        tick();
        beat("t5_rr2", 1'b1, 3'd6, 32'h56);
        tick();
        beat("t5_rr3", 1'b0, 3'd2, 32'h62);
        tick();
        chk("t5_end_vld", 64'(wb_vld), 64'(1'b0));

        // Flush with 2 mul + 1 div buffered and pulses on the flush cycle
        wb_rdy = 1'b0;
        drive(1'b1, 3'd1, 32'h71, 1'b0, 3'd0, 32'h0);
        drive(1'b1, 3'd2, 32'h72, 1'b1, 3'd3, 32'h73);
        chk("t6_mfull", 64'(mul_full), 64'(1'b1));
        beat("t6_pre", 1'b0, 3'd1, 32'h71);
        flush_ex = 1'b1;
        drive(1'b1, 3'd4, 32'h74, 1'b1, 3'd5, 32'h75);
        flush_ex = 1'b0;
        chk("t6_vld",   64'(wb_vld),   64'(1'b0));
        chk("t6_mfull0", 64'(mul_full), 64'(1'b0));
        chk("t6_dfull0", 64'(div_full), 64'(1'b0));
        wb_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_quiet", 64'(wb_vld), 64'(1'b0));
        end
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 32'h77);
        beat("t6_after", 1'b1, 3'd7, 32'h77);
        tick();
        chk("t6_after_end", 64'(wb_vld), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
